sample_mul_rr_sched: RTL and testbench
======================================

# sample_mul_rr_sched

Round-robin scheduler that shares the single pipelined 6x11 multiplier unit (sample_mul_mul_6n6jw, instantiated internally) among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block issues at most one product per cycle, tags it with the requester index, and returns results in issue order on one shared valid/ready result port. A global stall (multiplier ce low) is applied while the result port is back-pressured.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of res_id, equal to clog2(NUM_REQ).
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i holds a valid operand pair.
- req_ready  out  NUM_REQ  bit i: one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- req_a  in  NUM_REQ*6  operand A, unsigned, slice [6i+5:6i].
- req_b  in  NUM_REQ*11  operand B, signed two's complement, slice [11i+10:11i].
- res_valid  out  1  result present on res_p/res_id.
- res_ready  in  1  consumer accepts the result.
- res_id  out  ID_W  index of the requester that owns the result.
- res_p  out  11  product, signed, truncated.

## Operation
- Multiplier usage:
  - din0 = muxed req_a of the granted requester.
  - din1 = muxed req_b of the granted requester.
  - din0 and din1 are don't-care when nothing is granted.
  - ce = stall_n; res_p = dout.
  - The unit has 2 register stages (operand regs, then product reg), both gated by ce.
- Arithmetic: res_p = low 11 bits of ($signed({1'b0,a}) * $signed(b)). Overflow wraps silently; there is no saturation.
- stall_n = !(res_valid && !res_ready).
- Tag pipeline: 2 stages, each holding {v, id}, advanced only when stall_n is high.
  - Stage0 loads v = any grant and id = the granted index.
  - Stage1 loads from stage0.
  - res_valid = stage1.v; res_id = stage1.id.
- Arbitration: performed only when stall_n = 1. When stall_n = 0, req_ready is all zeros.
  - Search order starts at last+1 and proceeds modulo NUM_REQ.
  - The first requester with req_valid high is granted.
  - The pointer last updates to the granted index on each transfer, and is held when there is no transfer.
- req_ready may depend combinationally on req_valid and res_ready. Requesters must not make req_valid depend on req_ready.
- Once req_valid is asserted, a requester holds it with stable operands until the transfer.
- Bubbles: when stall_n = 1 and no request is granted, a v = 0 tag enters stage0. The multiplier still advances.
- Reset (asynchronous, at any time):
  - All tag stages clear to v = 0, id = 0.
  - last = NUM_REQ-1, so requester 0 has first priority.
  - In-flight products are discarded.
- Reset values of outputs:
  - req_ready = 0, res_valid = 0, res_id = 0.
  - res_p is undefined, because the multiplier datapath is not reset. It is meaningful only while res_valid = 1.

## Timing
- Latency: a transfer in cycle t (with no stall) gives res_valid = 1 with the correct res_p/res_id in cycle t+2. Each stall cycle adds one cycle of latency.
- Throughput: 1 result per cycle when res_ready is held high.
- Ordering: results appear strictly in grant order. No result is dropped or duplicated.
- Stall:
  - While res_valid = 1 and res_ready = 0, res_p, res_id and res_valid hold stable.
  - Stage0 and the operand registers also hold during the stall.
  - No grants are issued during the stall.
  - When res_ready rises, the held result is consumed in that cycle and the pipeline advances on the same edge.
- res_valid = 0 with res_ready = 0 is not a stall: stall_n = 1, and empty slots are filled.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,...,NUM_REQ-1,0,... Each requester waits at most NUM_REQ-1 cycles between grants.

## Test plan
- Single op: reset, then requester 2 presents a=5, b=-3 for one cycle with res_ready=1.
  - Grant occurs in cycle t.
  - In cycle t+2: res_valid=1, res_id=2, res_p=11'h7F1. res_valid=0 in t+3.
- Arithmetic corners:
  - a=63, b=1023 -> res_p=11'h3C1 (961).
  - a=63, b=-1024 -> 11'h400.
  - a=0, b=-1 -> 0.
  - a=1, b=-1024 -> 11'h400.
- Round-robin: NUM_REQ=4, all req_valid held high for 8 cycles, res_ready=1.
  - Grant sequence is 0,1,2,3,0,1,2,3.
  - res_id sequence is the same, delayed by 2 cycles.
  - Products match per-requester operands.
- Back-pressure: stream 6 ops, drop res_ready for 3 cycles while res_valid=1.
  - req_ready stays 0 throughout the stall.
  - res_p and res_id stay stable.
  - After release, all 6 results arrive in order with none lost or duplicated.
- Bubbles and sparse traffic: requester 1 valid only on alternating cycles.
  - res_valid pattern mirrors the issue pattern 2 cycles later.
  - No spurious res_valid.
- Reset mid-operation: assert reset asynchronously (not on a clock edge) with 2 ops in flight.
  - res_valid and req_ready go 0 immediately.
  - No stale result appears after reset release.
  - The first grant after reset goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/sample_mul_rr_sched_if.sv
// sample_mul_rr_sched_if
// Bundles the requester-side and result-side handshakes of the shared
// multiplier scheduler.
//   req_valid/req_ready : one valid/ready pair per requester
//   req_a               : packed 6-bit unsigned operands, slice [6i+5:6i]
//   req_b               : packed 11-bit signed operands, slice [11i+10:11i]
//   res_valid/res_ready : shared result handshake
//   res_id              : owner index of the presented result
//   res_p               : truncated signed product
// master = requesters plus result consumer, slave = the scheduler.
interface sample_mul_rr_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*6-1:0]  req_a;
   logic [NUM_REQ*11-1:0] req_b;
   logic                  res_valid;
   logic                  res_ready;
   logic [ID_W-1:0]       res_id;
   logic [10:0]           res_p;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_id, res_p
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_id, res_p
   );
endinterface

// File: rtl/sample_mul_rr_sched.sv
// sample_mul_mul_6n6jw
// Two-stage pipelined multiplier: 6-bit unsigned x 11-bit signed, keeping
// the low 11 bits of the product. Both stages advance only while ce is high.
// The datapath is deliberately not reset.
//   clk  : clock
//   ce   : stage enable
//   din0 : operand A (unsigned)
//   din1 : operand B (signed)
//   dout : low 11 bits of the signed product
module sample_mul_mul_6n6jw (
   input  logic        clk,
   input  logic        ce,
   input  logic [5:0]  din0,
   input  logic [10:0] din1,
   output logic [10:0] dout
);
   logic [5:0]         a_r;
   logic signed [10:0] b_r;
   logic signed [10:0] a_ext;
   logic signed [10:0] p_r;

   // Zero-extending A keeps it non-negative; the low 11 product bits only
   // depend on the low 11 bits of each operand, so an 11x11 multiply suffices.
   assign a_ext = {5'b0, a_r};

   // Stage 1 captures operands, stage 2 captures the truncated product.
   always_ff @(posedge clk) begin
      if (ce) begin
         a_r <= din0;
         b_r <= din1;
         p_r <= a_ext * b_r;
      end
   end

   assign dout = p_r;
endmodule

// sample_mul_rr_sched
// Round-robin scheduler sharing one pipelined multiplier among NUM_REQ
// requesters. Each product is tagged with its requester index and returned
// in issue order on a single valid/ready result port; back-pressure on that
// port freezes the whole pipeline.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : scheduler side of sample_mul_rr_sched_if
module sample_mul_rr_sched #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   sample_mul_rr_sched_if.slave bus
);
   logic               stall_n;
   logic               arb_en;
   logic               found;
   logic [ID_W-1:0]    grant_id;
   logic [NUM_REQ-1:0] grant_oh;
   logic [5:0]         mul_a;
   logic [10:0]        mul_b;
   logic [ID_W-1:0]    last;
   logic               s0_v;
   logic [ID_W-1:0]    s0_id;
   logic               s1_v;
   logic [ID_W-1:0]    s1_id;
   int                 idx;

   // The pipeline only freezes when a result is actually being refused;
   // an empty output slot never blocks new work.
   assign stall_n = !(s1_v && !bus.res_ready);

   // Grants are suppressed while reset is held so req_ready drops at once.
   assign arb_en = stall_n && !reset;

   // Search from the requester after the last winner, wrapping around, and
   // grant the first valid one. The same loop steers its operands into the
   // multiplier so no separate index mux is needed.
   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      grant_oh = '0;
      mul_a    = '0;
      mul_b    = '0;
      idx      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && arb_en && bus.req_valid[idx]) begin
            found         = 1'b1;
            grant_id      = ID_W'(idx);
            grant_oh[idx] = 1'b1;
            mul_a         = bus.req_a[idx*6 +: 6];
            mul_b         = bus.req_b[idx*11 +: 11];
         end
      end
   end

   // Tag pipeline runs in lock-step with the multiplier stages so that the
   // owner index lines up with its product. A grant implies stall_n, so the
   // round-robin pointer can simply follow every grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_v  <= 1'b0;
         s0_id <= '0;
         s1_v  <= 1'b0;
         s1_id <= '0;
         last  <= ID_W'(NUM_REQ - 1);
      end else begin
         if (stall_n) begin
            s0_v  <= found;
            s0_id <= grant_id;
            s1_v  <= s0_v;
            s1_id <= s0_id;
         end
         if (found) begin
            last <= grant_id;
         end
      end
   end

   sample_mul_mul_6n6jw u_mul (
      .clk  (clk),
      .ce   (stall_n),
      .din0 (mul_a),
      .din1 (mul_b),
      .dout (bus.res_p)
   );

   assign bus.req_ready = grant_oh;
   assign bus.res_valid = s1_v;
   assign bus.res_id    = s1_id;
endmodule

// File: tb/tb_sample_mul_rr_sched.sv
// tb_sample_mul_rr_sched
// Directed and randomized stimulus for sample_mul_rr_sched, checked each
// cycle against a transaction-level reference: a round-robin pick over the
// pending requesters, and a two-cycle (plus stalls) delivery line of
// expected results.
module tb_sample_mul_rr_sched;
   localparam int N = 4;

   typedef struct {
      bit          v;
      int          id;
      logic [10:0] p;
      bit          has_lit;
      logic [10:0] lit;
   } slot_t;

   logic clk;
   logic reset;
   logic res_rdy;

   sample_mul_rr_sched_if #(.NUM_REQ(N), .ID_W(2)) bus ();

   sample_mul_rr_sched #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit          pend [N];
   logic [5:0]  pa [N];
   logic [10:0] pb [N];
   bit          lflag [N];
   logic [10:0] lval [N];
   slot_t       m_s0;
   slot_t       m_s1;
   int          m_last;
   int          grant_log [$];
   int          n_consumed;
   int          n_checks;
   int          n_fails;

   // Reference product from the arithmetic rule: unsigned A times signed B,
   // keep the low 11 bits.
   function automatic logic [10:0] ref_prod(logic [5:0] a, logic [10:0] b);
      int full;
      full = int'(a) * int'($signed(b));
      return full[10:0];
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic post(int r, logic [5:0] a, logic [10:0] b, bit lit, logic [10:0] litv);
      pend[r]  = 1'b1;
      pa[r]    = a;
      pb[r]    = b;
      lflag[r] = lit;
      lval[r]  = litv;
   endtask

   task automatic post_rand(int r);
      post(r, 6'($urandom_range(63)), 11'($urandom_range(2047)), 1'b0, 11'h0);
   endtask

   task automatic model_reset();
      m_s0   = '{default: 0};
      m_s1   = '{default: 0};
      m_last = N - 1;
   endtask

   // Drive the pending requests and the consumer's ready onto the bus.
   task automatic applyStimulus();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]      = pend[i];
         bus.req_a[i*6 +: 6]   = pa[i];
         bus.req_b[i*11 +: 11] = pb[i];
      end
      bus.res_ready = res_rdy;
   endtask

   // Compare the DUT against the reference for this cycle, then advance the
   // reference as the coming clock edge will.
   task automatic checkOutput();
      bit    stall;
      int    g;
      int    r;
      logic [N-1:0] exp_oh;
      if (reset) begin
         check("req_ready_rst", bus.req_ready, 0);
         check("res_valid_rst", bus.res_valid, 0);
         check("res_id_rst", bus.res_id, 0);
         model_reset();
         return;
      end
      stall = m_s1.v && !res_rdy;
      g = -1;
      if (!stall) begin
         for (int k = 1; k <= N; k++) begin
            r = (m_last + k) % N;
            if (g < 0 && pend[r]) g = r;
         end
      end
      exp_oh = '0;
      if (g >= 0) exp_oh[g] = 1'b1;
      check("req_ready", bus.req_ready, exp_oh);
      check("res_valid", bus.res_valid, m_s1.v);
      if (m_s1.v) begin
         check("res_id", bus.res_id, m_s1.id);
         check("res_p", bus.res_p, m_s1.p);
         if (m_s1.has_lit) check("res_p_lit", bus.res_p, m_s1.lit);
         if (res_rdy) n_consumed++;
      end
      if (!stall) begin
         m_s1 = m_s0;
         m_s0 = '{default: 0};
         if (g >= 0) begin
            m_s0.v       = 1'b1;
            m_s0.id      = g;
            m_s0.p       = ref_prod(pa[g], pb[g]);
            m_s0.has_lit = lflag[g];
            m_s0.lit     = lval[g];
            m_last       = g;
            pend[g]      = 1'b0;
            grant_log.push_back(g);
         end
      end
   endtask

   task automatic step();
      applyStimulus();
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int posted;
      n_checks   = 0;
      n_fails    = 0;
      n_consumed = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; pa[i] = '0; pb[i] = '0; lflag[i] = 0; lval[i] = '0;
      end
      model_reset();
      res_rdy = 1'b1;
      reset   = 1'b1;
      applyStimulus();
      repeat (2) step();
      reset = 1'b0;

      $display("[TB] single op on requester 2");
      post(2, 6'd5, 11'h7FD, 1'b1, 11'h7F1);
      repeat (4) step();

      $display("[TB] arithmetic corners");
      post(0, 6'd63, 11'h3FF, 1'b1, 11'h3C1);
      post(1, 6'd63, 11'h400, 1'b1, 11'h400);
      post(2, 6'd0,  11'h7FF, 1'b1, 11'h000);
      post(3, 6'd1,  11'h400, 1'b1, 11'h400);
      repeat (7) step();

      $display("[TB] round-robin rotation");
      reset = 1'b1;
      step();
      reset = 1'b0;
      grant_log.delete();
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < N; r++) if (!pend[r]) post_rand(r);
         step();
      end
      for (int r = 0; r < N; r++) pend[r] = 0;
      check("rr_count", grant_log.size(), 8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         check("rr_order", grant_log[i], i % N);
      repeat (3) step();

      $display("[TB] back-pressure");
      base   = n_consumed;
      posted = 0;
      for (int c = 0; c < 12; c++) begin
         res_rdy = !(c >= 3 && c <= 5);
         for (int r = 0; r < N; r++)
            if (!pend[r] && posted < 6) begin
               post_rand(r);
               posted++;
            end
         step();
      end
      res_rdy = 1'b1;
      repeat (4) step();
      check("bp_results", n_consumed - base, 6);

      $display("[TB] sparse traffic");
      for (int c = 0; c < 10; c++) begin
         if (c % 2 == 0) post_rand(1);
         step();
      end
      repeat (3) step();

      $display("[TB] random traffic");
      for (int c = 0; c < 300; c++) begin
         res_rdy = ($urandom_range(3) != 0);
         for (int r = 0; r < N; r++)
            if (!pend[r] && $urandom_range(99) < 40) post_rand(r);
         step();
      end
      res_rdy = 1'b1;
      for (int r = 0; r < N; r++) pend[r] = 0;
      repeat (4) step();

      $display("[TB] reset mid-operation");
      post_rand(0);
      post_rand(1);
      step();
      step();
      for (int r = 0; r < N; r++) if (!pend[r]) post_rand(r);
      applyStimulus();
      #2;
      reset = 1'b1;
      #1;
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_req_ready", bus.req_ready, 0);
      model_reset();
      step();
      reset = 1'b0;
      #1;
      check("post_rst_grant", bus.req_ready, 4'b0001);
      repeat (8) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
